mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage between EX and WB of the 5-stage PA-RISC pipeline. It contains the EX/MEM pipeline register, a 256-byte big-endian data RAM with byte, halfword and word access, and a wait-state FSM that stalls the pipeline on slow accesses. It also contains the MEM/WB pipeline register. It produces the MEM-stage forwarding value (PD_MEM) for ID and the write-back triplet for the register file.

Parameters:
WAIT_CYCLES, 0, extra cycles each enabled RAM access occupies (0..15); 0 means a single-cycle access.
DEPTH, 256, data RAM size in bytes; address is EX_OUT[7:0].

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous active-high reset
LE  in  1  pipeline advance from the hazard unit; EX/MEM loads only when LE && !MEM_STALL
EX_OUT  in  32  ALU result or return address; low 8 bits are the RAM byte address
EX_DI  in  32  store data (forwarded RB)
EX_RD  in  5  destination register
EX_L  in  1  1 = write-back value comes from RAM data-out
EX_RF_LE  in  1  register-file write enable
RAM_CTRL  in  4  [3] E enable, [2] W (1 = store), [1:0] size: 00 byte, 01 half, 10 word, 11 word
PD_MEM  out  32  combinational MEM-stage result for forwarding
MEM_RD  out  5  EX/MEM destination register, used by the hazard unit
MEM_RF_LE  out  1  EX/MEM RF_LE, used by the hazard unit
MEM_STALL  out  1  high while an access is still in wait states
MEM_MISALIGN  out  1  one-cycle pulse on a suppressed misaligned access
WB_PW  out  32  MEM/WB write data
WB_RD  out  5  MEM/WB destination register
WB_RF_LE  out  1  MEM/WB write enable

Behaviour:
- Reset: all EX/MEM and MEM/WB fields go to 0, the FSM goes to IDLE, the wait counter goes to 0, and MEM_STALL and MEM_MISALIGN go to 0. RAM contents are not altered by reset.
- EX/MEM register: if LE && !MEM_STALL, it captures all inputs on the clock edge. If !LE && !MEM_STALL, it holds its contents.
- Alignment: a half access is misaligned when addr[0]=1; a word access is misaligned when addr[1:0]!=0.
- Endianness is big-endian: a word at address a returns {M[a], M[a+1], M[a+2], M[a+3]}. Loads are zero-extended.
- Store, byte: writes EX_DI[7:0] to M[a].
- Store, half: writes EX_DI[15:0] to M[a..a+1].
- Store, word: writes EX_DI to M[a..a+3].
- FSM states:
  - IDLE: entered whenever the EX/MEM entry has E=1 and is aligned. If WAIT_CYCLES=0, the access completes this cycle: the store commits at the edge and load data is valid combinationally. Otherwise the counter loads WAIT_CYCLES, the FSM moves to BUSY, and MEM_STALL=1.
  - BUSY: MEM_STALL=1 and the counter decrements each cycle. When the counter reaches 1, the next cycle returns to IDLE-complete: MEM_STALL=0, the store commits, and load data is valid.
  - A newly captured entry must not restart an access already completed: this is tracked with a per-entry done flag that clears on each EX/MEM capture.
- Total occupancy: a stalled access holds EX/MEM for exactly WAIT_CYCLES cycles beyond the first.
- Misaligned access:
  - No RAM write occurs and no stall occurs.
  - MEM_MISALIGN=1 for the cycle the entry is in MEM.
  - Load data reads as 0.
  - The RF_LE propagated to MEM/WB is forced to 0.
- PD_MEM: equals the load data when EX_L=1, otherwise the registered EX_OUT. When no entry is valid it equals 0 after reset.
- MEM/WB register:
  - When !MEM_STALL, it loads {PD_MEM, MEM_RD, MEM_RF_LE}, with RF_LE gated by misalignment.
  - While MEM_STALL=1, it loads a bubble with WB_RF_LE=0; WB_PW and WB_RD are don't-care but must hold their previous values.
- Unconditional reads: RAM reads are non-destructive. An entry with E=0 performs no RAM access, passes EX_OUT through, and never stalls.
- Reset during BUSY: the access is aborted, no store commits, the FSM goes to IDLE, and MEM_STALL=0 in the following cycle.
- Simultaneous LE=0 and completion: the completed result still enters MEM/WB, and the EX/MEM entry is held but marked done, so no second access occurs.

Test Plan:
1. WAIT_CYCLES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> PD_MEM=0xDEADBEEF in the load's MEM cycle; WB_PW=0xDEADBEEF and WB_RF_LE=1 one cycle later; MEM_STALL never asserted.
2. After test 1: store byte 0xAB at 0x13, then load word at 0x10 -> 0xDEADBEAB; load byte at 0x11 -> 0x000000AD.
3. After test 2: load half at 0x12 -> 0x0000BEAB; load half at 0x10 -> 0x0000DEAD.
4. WAIT_CYCLES=2: load word at 0x10 -> MEM_STALL=1 for exactly 2 cycles; WB_RF_LE=0 during both; EX/MEM holds despite LE=1; the result 0xDEADBEAB reaches WB on the cycle after the stall drops.
5. Store word at 0x11 -> MEM_MISALIGN=1 for 1 cycle, M[0x10..0x13] unchanged, no stall. A misaligned load has WB_RF_LE=0.
6. WAIT_CYCLES=3: a store to 0x20 has RST asserted on its second BUSY cycle -> M[0x20..0x23] unchanged; all outputs 0 next cycle; the FSM accepts a new access immediately after.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage PA-RISC pipeline: EX/MEM register, big-endian byte-addressed data RAM
// with a wait-state FSM, and the MEM/WB register feeding the register file.
module mem_stage #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned DEPTH       = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LE,
  input  logic [31:0] EX_OUT,
  input  logic [31:0] EX_DI,
  input  logic [4:0]  EX_RD,
  input  logic        EX_L,
  input  logic        EX_RF_LE,
  input  logic [3:0]  RAM_CTRL,
  output logic [31:0] PD_MEM,
  output logic [4:0]  MEM_RD,
  output logic        MEM_RF_LE,
  output logic        MEM_STALL,
  output logic        MEM_MISALIGN,
  output logic [31:0] WB_PW,
  output logic [4:0]  WB_RD,
  output logic        WB_RF_LE
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // EX/MEM register
  logic [31:0] mem_out_q;
  logic [31:0] mem_di_q;
  logic [4:0]  mem_rd_q;
  logic        mem_l_q;
  logic        mem_rf_le_q;
  logic [3:0]  mem_ctrl_q;
  logic        done_q;

  // Wait-state FSM
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall;
  logic        complete;

  // MEM/WB register
  logic [31:0] wb_pw_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rf_le_q;

  logic [7:0]  ram [DEPTH];

  logic          ram_e;
  logic          ram_w;
  logic [1:0]    ram_sz;
  logic          misaligned;
  logic          mis;
  logic          mis_pulse;
  logic          acc;
  logic          capture;
  logic          ram_we;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   load_data;
  logic [31:0]   pd_mem;

  assign ram_e  = mem_ctrl_q[3];
  assign ram_w  = mem_ctrl_q[2];
  assign ram_sz = mem_ctrl_q[1:0];

  assign a0 = mem_out_q[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  always_comb begin
    misaligned = 1'b0;
    case (ram_sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_out_q[0];
      default: misaligned = (mem_out_q[1:0] != 2'b00);
    endcase
  end

  assign mis       = ram_e && misaligned;
  // done_q keeps a held entry from being accessed (or flagged) a second time
  assign mis_pulse = mis && !done_q;
  assign acc       = ram_e && !misaligned && !done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StBusy;
            cnt_d   = WaitInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q <= 4'd1) begin
          complete = 1'b1;
          state_d  = StIdle;
          cnt_d    = 4'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign capture = LE && !stall;
  assign ram_we  = complete && ram_w && !RST;

  always_comb begin
    load_data = 32'h0;
    if (!mis) begin
      case (ram_sz)
        2'b00:   load_data = {24'h0, ram[a0]};
        2'b01:   load_data = {16'h0, ram[a0], ram[a1]};
        default: load_data = {ram[a0], ram[a1], ram[a2], ram[a3]};
      endcase
    end
  end

  assign pd_mem = (ram_e && mem_l_q) ? load_data : mem_out_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_out_q   <= 32'h0;
      mem_di_q    <= 32'h0;
      mem_rd_q    <= 5'd0;
      mem_l_q     <= 1'b0;
      mem_rf_le_q <= 1'b0;
      mem_ctrl_q  <= 4'h0;
      done_q      <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      wb_pw_q     <= 32'h0;
      wb_rd_q     <= 5'd0;
      wb_rf_le_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        mem_out_q   <= EX_OUT;
        mem_di_q    <= EX_DI;
        mem_rd_q    <= EX_RD;
        mem_l_q     <= EX_L;
        mem_rf_le_q <= EX_RF_LE;
        mem_ctrl_q  <= RAM_CTRL;
        done_q      <= 1'b0;
      end else if (complete || mis_pulse) begin
        done_q <= 1'b1;
      end
      // A stalled access sends a bubble; payload fields keep their last value
      if (stall) begin
        wb_rf_le_q <= 1'b0;
      end else begin
        wb_pw_q    <= pd_mem;
        wb_rd_q    <= mem_rd_q;
        wb_rf_le_q <= mem_rf_le_q && !mis;
      end
    end
  end

  // RAM contents survive reset; a store aborted by reset never commits
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      case (ram_sz)
        2'b00: begin
          ram[a0] <= mem_di_q[7:0];
        end
        2'b01: begin
          ram[a0] <= mem_di_q[15:8];
          ram[a1] <= mem_di_q[7:0];
        end
        default: begin
          ram[a0] <= mem_di_q[31:24];
          ram[a1] <= mem_di_q[23:16];
          ram[a2] <= mem_di_q[15:8];
          ram[a3] <= mem_di_q[7:0];
        end
      endcase
    end
  end

  assign PD_MEM       = pd_mem;
  assign MEM_RD       = mem_rd_q;
  assign MEM_RF_LE    = mem_rf_le_q;
  assign MEM_STALL    = stall;
  assign MEM_MISALIGN = mis_pulse;
  assign WB_PW        = wb_pw_q;
  assign WB_RD        = wb_rd_q;
  assign WB_RF_LE     = wb_rf_le_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with WAIT_CYCLES = 0, 2 and 3, each driven
// independently from index-selected input arrays.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        le        [3];
  logic [31:0] ex_out    [3];
  logic [31:0] ex_di     [3];
  logic [4:0]  ex_rd     [3];
  logic        ex_l      [3];
  logic        ex_rf_le  [3];
  logic [3:0]  ram_ctrl  [3];
  logic [31:0] pd_mem    [3];
  logic [4:0]  mem_rd    [3];
  logic        mem_rf_le [3];
  logic        mem_stall [3];
  logic        mem_mis   [3];
  logic [31:0] wb_pw     [3];
  logic [4:0]  wb_rd     [3];
  logic        wb_rf_le  [3];

  int errors = 0;
  int checks = 0;

  mem_stage #(.WAIT_CYCLES(0), .DEPTH(256)) u_w0 (
    .CLK(clk), .RST(rst), .LE(le[0]), .EX_OUT(ex_out[0]), .EX_DI(ex_di[0]), .EX_RD(ex_rd[0]),
    .EX_L(ex_l[0]), .EX_RF_LE(ex_rf_le[0]), .RAM_CTRL(ram_ctrl[0]), .PD_MEM(pd_mem[0]),
    .MEM_RD(mem_rd[0]), .MEM_RF_LE(mem_rf_le[0]), .MEM_STALL(mem_stall[0]),
    .MEM_MISALIGN(mem_mis[0]), .WB_PW(wb_pw[0]), .WB_RD(wb_rd[0]), .WB_RF_LE(wb_rf_le[0])
  );

  mem_stage #(.WAIT_CYCLES(2), .DEPTH(256)) u_w2 (
    .CLK(clk), .RST(rst), .LE(le[1]), .EX_OUT(ex_out[1]), .EX_DI(ex_di[1]), .EX_RD(ex_rd[1]),
    .EX_L(ex_l[1]), .EX_RF_LE(ex_rf_le[1]), .RAM_CTRL(ram_ctrl[1]), .PD_MEM(pd_mem[1]),
    .MEM_RD(mem_rd[1]), .MEM_RF_LE(mem_rf_le[1]), .MEM_STALL(mem_stall[1]),
    .MEM_MISALIGN(mem_mis[1]), .WB_PW(wb_pw[1]), .WB_RD(wb_rd[1]), .WB_RF_LE(wb_rf_le[1])
  );

  mem_stage #(.WAIT_CYCLES(3), .DEPTH(256)) u_w3 (
    .CLK(clk), .RST(rst), .LE(le[2]), .EX_OUT(ex_out[2]), .EX_DI(ex_di[2]), .EX_RD(ex_rd[2]),
    .EX_L(ex_l[2]), .EX_RF_LE(ex_rf_le[2]), .RAM_CTRL(ram_ctrl[2]), .PD_MEM(pd_mem[2]),
    .MEM_RD(mem_rd[2]), .MEM_RF_LE(mem_rf_le[2]), .MEM_STALL(mem_stall[2]),
    .MEM_MISALIGN(mem_mis[2]), .WB_PW(wb_pw[2]), .WB_RD(wb_rd[2]), .WB_RF_LE(wb_rf_le[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic le_v, input logic [31:0] o,
                       input logic [31:0] di, input logic [4:0] rd_v, input logic l_v,
                       input logic rf_v, input logic [3:0] ctrl_v);
    le[d]       = le_v;
    ex_out[d]   = o;
    ex_di[d]    = di;
    ex_rd[d]    = rd_v;
    ex_l[d]     = l_v;
    ex_rf_le[d] = rf_v;
    ram_ctrl[d] = ctrl_v;
  endtask

  task automatic bubble(input int d);
    drive(d, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 4'h0);
  endtask

  // Bounded wait for the stall on instance d to drop
  task automatic wait_done(input int d, input string tag);
    int n = 0;
    while (mem_stall[d] === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (mem_stall[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: stall=%b want 0", tag, mem_stall[d]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) bubble(d);
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({pd_mem[d], mem_rd[d], mem_rf_le[d], mem_stall[d], mem_mis[d], wb_pw[d], wb_rd[d],
           wb_rf_le[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: pd=%h rd=%h st=%b mis=%b wb=%h/%h/%b want all 0",
                 d, pd_mem[d], mem_rd[d], mem_stall[d], mem_mis[d], wb_pw[d], wb_rd[d],
                 wb_rf_le[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 4'b1110);
    step();
    checks++;
    if (mem_stall[0] !== 1'b0) begin
      errors++; $display("FAIL word_store_stall: got %b want 0", mem_stall[0]);
    end
    drive(0, 1'b1, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1, 4'b1010);
    step();
    checks++;
    if (pd_mem[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load_pd: got %h want deadbeef", pd_mem[0]);
    end
    checks++;
    if ({mem_rd[0], mem_rf_le[0], mem_stall[0]} !== {5'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL word_load_mem: rd=%0d rf=%b st=%b want 7 1 0", mem_rd[0], mem_rf_le[0],
               mem_stall[0]);
    end
    bubble(0);
    step();
    checks++;
    if ({wb_pw[0], wb_rd[0], wb_rf_le[0]} !== {32'hDEADBEEF, 5'd7, 1'b1}) begin
      errors++;
      $display("FAIL word_load_wb: got %h/%0d/%b want deadbeef/7/1", wb_pw[0], wb_rd[0],
               wb_rf_le[0]);
    end
  endtask

  task automatic test_byte;
    drive(0, 1'b1, 32'h13, 32'h000000AB, 5'd0, 1'b0, 1'b0, 4'b1100);
    step();
    drive(0, 1'b1, 32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 4'b1010);
    step();
    checks++;
    if (pd_mem[0] !== 32'hDEADBEAB) begin
      errors++; $display("FAIL byte_merge_pd: got %h want deadbeab", pd_mem[0]);
    end
    drive(0, 1'b1, 32'h11, 32'h0, 5'd9, 1'b1, 1'b1, 4'b1000);
    step();
    checks++;
    if (pd_mem[0] !== 32'h000000AD) begin
      errors++; $display("FAIL byte_load_pd: got %h want 000000ad", pd_mem[0]);
    end
    checks++;
    if ({wb_pw[0], wb_rd[0]} !== {32'hDEADBEAB, 5'd8}) begin
      errors++; $display("FAIL byte_prev_wb: got %h/%0d want deadbeab/8", wb_pw[0], wb_rd[0]);
    end
    bubble(0);
    step();
    checks++;
    if ({wb_pw[0], wb_rd[0], wb_rf_le[0]} !== {32'h000000AD, 5'd9, 1'b1}) begin
      errors++;
      $display("FAIL byte_load_wb: got %h/%0d/%b want 000000ad/9/1", wb_pw[0], wb_rd[0],
               wb_rf_le[0]);
    end
  endtask

  task automatic test_half;
    drive(0, 1'b1, 32'h12, 32'h0, 5'd10, 1'b1, 1'b1, 4'b1001);
    step();
    checks++;
    if (pd_mem[0] !== 32'h0000BEAB) begin
      errors++; $display("FAIL half_12_pd: got %h want 0000beab", pd_mem[0]);
    end
    drive(0, 1'b1, 32'h10, 32'h0, 5'd11, 1'b1, 1'b1, 4'b1001);
    step();
    checks++;
    if (pd_mem[0] !== 32'h0000DEAD) begin
      errors++; $display("FAIL half_10_pd: got %h want 0000dead", pd_mem[0]);
    end
    // E=0 entry: no RAM access, EX_OUT passes through
    drive(0, 1'b1, 32'h12345678, 32'h0, 5'd3, 1'b0, 1'b1, 4'b0000);
    step();
    checks++;
    if ({pd_mem[0], mem_rf_le[0], mem_stall[0]} !== {32'h12345678, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL passthru_pd: got %h/%b/%b want 12345678/1/0", pd_mem[0], mem_rf_le[0],
               mem_stall[0]);
    end
    bubble(0);
    step();
    checks++;
    if ({wb_pw[0], wb_rd[0], wb_rf_le[0]} !== {32'h12345678, 5'd3, 1'b1}) begin
      errors++;
      $display("FAIL passthru_wb: got %h/%0d/%b want 12345678/3/1", wb_pw[0], wb_rd[0],
               wb_rf_le[0]);
    end
  endtask

  task automatic test_wait;
    drive(1, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 4'b1110);
    step();
    bubble(1);
    wait_done(1, "pre_word");
    drive(1, 1'b1, 32'h13, 32'h000000AB, 5'd0, 1'b0, 1'b0, 4'b1100);
    step();
    bubble(1);
    wait_done(1, "pre_byte");
    drive(1, 1'b1, 32'h10, 32'h0, 5'd11, 1'b1, 1'b1, 4'b1010);
    step();
    bubble(1);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if ({mem_stall[1], wb_rf_le[1], mem_rd[1]} !== {1'b1, 1'b0, 5'd11}) begin
        errors++;
        $display("FAIL wait_stall_c%0d: st=%b wbrf=%b rd=%0d want 1 0 11", c, mem_stall[1],
                 wb_rf_le[1], mem_rd[1]);
      end
      step();
    end
    checks++;
    if ({mem_stall[1], pd_mem[1], mem_rd[1], wb_rf_le[1]} !==
        {1'b0, 32'hDEADBEAB, 5'd11, 1'b0}) begin
      errors++;
      $display("FAIL wait_complete: st=%b pd=%h rd=%0d wbrf=%b want 0 deadbeab 11 0",
               mem_stall[1], pd_mem[1], mem_rd[1], wb_rf_le[1]);
    end
    step();
    checks++;
    if ({wb_pw[1], wb_rd[1], wb_rf_le[1], mem_rd[1]} !== {32'hDEADBEAB, 5'd11, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL wait_wb: got %h/%0d/%b memrd=%0d want deadbeab/11/1 0", wb_pw[1],
               wb_rd[1], wb_rf_le[1], mem_rd[1]);
    end
  endtask

  task automatic test_hold_done;
    drive(1, 1'b1, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1, 4'b1010);
    step();
    drive(1, 1'b0, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1, 4'b1010);
    wait_done(1, "hold");
    step();
    checks++;
    if ({mem_stall[1], mem_rd[1]} !== {1'b0, 5'd12}) begin
      errors++;
      $display("FAIL hold_no_restart: st=%b rd=%0d want 0 12", mem_stall[1], mem_rd[1]);
    end
    checks++;
    if ({wb_pw[1], wb_rd[1], wb_rf_le[1]} !== {32'hDEADBEAB, 5'd12, 1'b1}) begin
      errors++;
      $display("FAIL hold_wb: got %h/%0d/%b want deadbeab/12/1", wb_pw[1], wb_rd[1],
               wb_rf_le[1]);
    end
    step();
    checks++;
    if (mem_stall[1] !== 1'b0) begin
      errors++; $display("FAIL hold_no_restart2: st=%b want 0", mem_stall[1]);
    end
    bubble(1);
    step();
  endtask

  task automatic test_misalign;
    drive(1, 1'b1, 32'h11, 32'h11223344, 5'd0, 1'b0, 1'b0, 4'b1110);
    step();
    bubble(1);
    checks++;
    if ({mem_mis[1], mem_stall[1]} !== 2'b10) begin
      errors++;
      $display("FAIL mis_store_flag: mis=%b st=%b want 1 0", mem_mis[1], mem_stall[1]);
    end
    step();
    checks++;
    if (mem_mis[1] !== 1'b0) begin
      errors++; $display("FAIL mis_pulse_width: mis=%b want 0", mem_mis[1]);
    end
    drive(1, 1'b1, 32'h10, 32'h0, 5'd13, 1'b1, 1'b1, 4'b1010);
    step();
    bubble(1);
    wait_done(1, "mis_reload");
    checks++;
    if (pd_mem[1] !== 32'hDEADBEAB) begin
      errors++; $display("FAIL mis_mem_unchanged: got %h want deadbeab", pd_mem[1]);
    end
    drive(1, 1'b1, 32'h13, 32'h0, 5'd14, 1'b1, 1'b1, 4'b1001);
    step();
    bubble(1);
    checks++;
    if ({mem_mis[1], mem_stall[1], pd_mem[1]} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL mis_load_mem: mis=%b st=%b pd=%h want 1 0 0", mem_mis[1], mem_stall[1],
               pd_mem[1]);
    end
    step();
    checks++;
    if ({wb_pw[1], wb_rd[1], wb_rf_le[1]} !== {32'h0, 5'd14, 1'b0}) begin
      errors++;
      $display("FAIL mis_load_wb: got %h/%0d/%b want 0/14/0", wb_pw[1], wb_rd[1], wb_rf_le[1]);
    end
  endtask

  task automatic test_reset_busy;
    drive(2, 1'b1, 32'h20, 32'h0BADF00D, 5'd0, 1'b0, 1'b0, 4'b1110);
    step();
    bubble(2);
    wait_done(2, "rb_pre");
    drive(2, 1'b1, 32'h20, 32'hCAFEBABE, 5'd0, 1'b0, 1'b0, 4'b1110);
    step();
    bubble(2);
    step();
    step();
    checks++;
    if (mem_stall[2] !== 1'b1) begin
      errors++; $display("FAIL rb_busy2_stall: st=%b want 1", mem_stall[2]);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({pd_mem[2], mem_rd[2], mem_rf_le[2], mem_stall[2], mem_mis[2], wb_pw[2], wb_rd[2],
         wb_rf_le[2]} !== '0) begin
      errors++;
      $display("FAIL rb_outputs_zero: pd=%h st=%b wb=%h/%0d/%b want all 0", pd_mem[2],
               mem_stall[2], wb_pw[2], wb_rd[2], wb_rf_le[2]);
    end
    rst = 1'b0;
    drive(2, 1'b1, 32'h20, 32'h0, 5'd15, 1'b1, 1'b1, 4'b1010);
    step();
    bubble(2);
    checks++;
    if ({mem_stall[2], mem_rd[2]} !== {1'b1, 5'd15}) begin
      errors++;
      $display("FAIL rb_accept: st=%b rd=%0d want 1 15", mem_stall[2], mem_rd[2]);
    end
    wait_done(2, "rb_load");
    checks++;
    if (pd_mem[2] !== 32'h0BADF00D) begin
      errors++; $display("FAIL rb_no_commit: got %h want 0badf00d", pd_mem[2]);
    end
    step();
    checks++;
    if ({wb_pw[2], wb_rd[2], wb_rf_le[2]} !== {32'h0BADF00D, 5'd15, 1'b1}) begin
      errors++;
      $display("FAIL rb_wb: got %h/%0d/%b want 0badf00d/15/1", wb_pw[2], wb_rd[2], wb_rf_le[2]);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wait();
    test_hold_done();
    test_misalign();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
